// File: rtl/trimmed_mean_filter_if.sv
// Sample-in / result-out bundle for the trimmed-mean filter.
// The slave modport is the filter itself; the master modport is its environment.
interface trimmed_mean_filter_if;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        filter_valid;
  logic [15:0] filter_data;
  logic [7:0]  drop_cnt;

  modport slave (
    input  sample_valid,
    input  sample_data,
    output filter_valid,
    output filter_data,
    output drop_cnt
  );

  modport master (
    output sample_valid,
    output sample_data,
    input  filter_valid,
    input  filter_data,
    input  drop_cnt
  );
endinterface

// File: rtl/trimmed_mean_filter.sv
// Block trimmed-mean filter: collects N+2 raw samples, removes one minimum and
// one maximum, and emits the round-half-up mean of the remaining N samples.
// A sample arriving while the window is being reduced is dropped and counted.
module trimmed_mean_filter #(
  parameter int LOG2_N = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  trimmed_mean_filter_if.slave  bus
);

  localparam int N  = 1 << LOG2_N;
  localparam int AW = 16 + LOG2_N + 1;       // holds (N+2)*65535 without overflow
  localparam int CW = $clog2(N + 2);

  localparam logic [CW-1:0] LAST_IDX = CW'(N + 1);
  localparam logic [AW-1:0] HALF     = AW'(N / 2);

  typedef enum logic [1:0] {
    S_ACC,
    S_TRIM,
    S_OUT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [15:0]   min_q, min_d;
  logic [15:0]   max_q, max_d;
  logic [AW-1:0] trim_q, trim_d;
  logic          filter_valid_q, filter_valid_d;
  logic [15:0]   filter_data_q, filter_data_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic [AW-1:0] round_sum;

  // Next-state and datapath updates; clear overrides everything but reset.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    min_d          = min_q;
    max_d          = max_q;
    trim_d         = trim_q;
    filter_valid_d = 1'b0;
    filter_data_d  = filter_data_q;
    drop_cnt_d     = drop_cnt_q;
    round_sum      = trim_q + HALF;

    if (clear) begin
      // Abort the window; any sample in this cycle is neither used nor dropped.
      state_d = S_ACC;
      cnt_d   = '0;
      acc_d   = '0;
      min_d   = 16'hFFFF;
      max_d   = 16'h0000;
    end else begin
      unique case (state_q)
        S_ACC: begin
          if (bus.sample_valid) begin
            acc_d = acc_q + AW'(bus.sample_data);
            if (bus.sample_data < min_q) min_d = bus.sample_data;
            if (bus.sample_data > max_q) max_d = bus.sample_data;
            if (cnt_q == LAST_IDX) begin
              state_d = S_TRIM;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        S_TRIM: begin
          trim_d  = acc_q - AW'(min_q) - AW'(max_q);
          state_d = S_OUT;
        end
        S_OUT: begin
          filter_data_d  = round_sum[LOG2_N +: 16];
          filter_valid_d = 1'b1;
          state_d        = S_ACC;
          cnt_d          = '0;
          acc_d          = '0;
          min_d          = 16'hFFFF;
          max_d          = 16'h0000;
        end
        default: state_d = S_ACC;
      endcase

      // Busy states cannot take a sample: discard it and count, saturating.
      if (state_q != S_ACC && bus.sample_valid && drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q        <= S_ACC;
      cnt_q          <= '0;
      acc_q          <= '0;
      min_q          <= 16'hFFFF;
      max_q          <= 16'h0000;
      trim_q         <= '0;
      filter_valid_q <= 1'b0;
      filter_data_q  <= 16'h0000;
      drop_cnt_q     <= 8'h00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      min_q          <= min_d;
      max_q          <= max_d;
      trim_q         <= trim_d;
      filter_valid_q <= filter_valid_d;
      filter_data_q  <= filter_data_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign bus.filter_valid = filter_valid_q;
  assign bus.filter_data  = filter_data_q;
  assign bus.drop_cnt     = drop_cnt_q;

endmodule
